link_frame_scheduler: RTL and testbench

//  Shares the single CRC8-encode -> 2FSK mod -> channel -> demod -> CRC8-decode link among NUM_REQ byte requesters.

---
 rtl/link_pkg.sv | 8 +
 rtl/link_frame_scheduler_if.sv | 26 ++
 rtl/link_frame_scheduler_rr_arbiter.sv | 25 ++
 rtl/link_frame_scheduler.sv | 100 ++++++++++
 tb/tb_link_frame_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared types and frame constants for the link frame scheduler.
package link_pkg;
    typedef enum logic [2:0] {IDLE, ALIGN, SEND, WAIT_RX, CHECK, DONE} state_t;
    localparam int DATA_W = 8;
    localparam int CODE_W = 16;
    localparam int SIGN_W = $clog2(CODE_W);
    localparam logic [SIGN_W-1:0] FRAME_LAST = SIGN_W'(CODE_W - 1);
endpackage

// File: rtl/link_frame_scheduler_if.sv
// link_frame_scheduler_if: requester, bit-timing and codec signals of the shared link.
interface link_frame_scheduler_if #(parameter int NUM_REQ = 4);
    import link_pkg::*;
    localparam int IW = $clog2(NUM_REQ);
    logic                      bit_tick;
    logic [SIGN_W-1:0]         sign_cnt;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_en;
    logic [DATA_W-1:0]         rx_data;
    logic                      rx_crc_ok;
    logic                      done;
    logic                      done_ok;
    logic [IW-1:0]             done_id;
    logic                      busy;
    modport master (
        input  bit_tick, sign_cnt, req, req_data, rx_data, rx_crc_ok,
        output grant, tx_data, tx_en, done, done_ok, done_id, busy
    );
    modport slave (
        output bit_tick, sign_cnt, req, req_data, rx_data, rx_crc_ok,
        input  grant, tx_data, tx_en, done, done_ok, done_id, busy
    );
endinterface

// File: rtl/link_frame_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requester at or after pointer+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index
);
    logic [IW-1:0] j;
    // Scan farthest-first so the nearest candidate after the pointer is written last.
    always_comb begin
        grant = '0;
        index = '0;
        j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(pointer) + 1 + k) % NUM_REQ);
            if (req[j]) begin
                grant = NUM_REQ'(1) << j;
                index = j;
            end
        end
    end
endmodule

// File: rtl/link_frame_scheduler.sv
// link_frame_scheduler: round-robin owner of the CRC8/2FSK link, frame-aligned transmit
// with receive check and bounded retransmission.
module link_frame_scheduler
    import link_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MAX_RETRY     = 2,
    parameter int RX_LAG_FRAMES = 1
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    link_frame_scheduler_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam int LW = $clog2(RX_LAG_FRAMES + 1);

    state_t             state;
    logic [IW-1:0]      pointer;
    logic [IW-1:0]      id;
    logic [DATA_W-1:0]  data_q;
    logic [RW-1:0]      retry_cnt;
    logic [LW-1:0]      lag_cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_index;
    logic               frame_end;
    logic               rx_ok;

    assign frame_end = bus.bit_tick & (bus.sign_cnt == FRAME_LAST);
    assign rx_ok     = bus.rx_crc_ok & (bus.rx_data == data_q);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .pointer (pointer),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pointer     <= '0;
            id          <= '0;
            data_q      <= '0;
            retry_cnt   <= '0;
            lag_cnt     <= '0;
            bus.grant   <= '0;
            bus.tx_data <= '0;
            bus.tx_en   <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_ok <= 1'b0;
            bus.done_id <= '0;
            bus.busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (|bus.req) begin
                    bus.grant <= arb_grant;
                    bus.busy  <= 1'b1;
                    id        <= arb_index;
                    data_q    <= bus.req_data[arb_index*DATA_W +: DATA_W];
                    state     <= ALIGN;
                end
                ALIGN: if (frame_end) begin
                    bus.tx_data <= data_q;
                    bus.tx_en   <= 1'b1;
                    state       <= SEND;
                end
                // Idle frames carry zero so the encoder never sees stale data.
                SEND: if (frame_end) begin
                    bus.tx_data <= '0;
                    bus.tx_en   <= 1'b0;
                    lag_cnt     <= LW'(RX_LAG_FRAMES);
                    state       <= WAIT_RX;
                end
                WAIT_RX: if (frame_end) begin
                    lag_cnt <= lag_cnt - 1'b1;
                    if (lag_cnt == LW'(1)) state <= CHECK;
                end
                CHECK: if (rx_ok || retry_cnt == RW'(MAX_RETRY)) begin
                    bus.done    <= 1'b1;
                    bus.done_ok <= rx_ok;
                    bus.done_id <= id;
                    bus.grant   <= '0;
                    bus.busy    <= 1'b0;
                    pointer     <= id;
                    retry_cnt   <= '0;
                    state       <= DONE;
                end else begin
                    retry_cnt <= retry_cnt + 1'b1;
                    state     <= ALIGN;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_link_frame_scheduler.sv
// tb_link_frame_scheduler: directed checks of arbitration order, frame alignment,
// retry behaviour and asynchronous reset of the link frame scheduler.
module tb_link_frame_scheduler;
    import link_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    link_frame_scheduler_if #(.NUM_REQ(4)) bus();

    link_frame_scheduler #(.NUM_REQ(4), .MAX_RETRY(2), .RX_LAG_FRAMES(1)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Bit period of 4 clocks, 16 bits per frame: one frame every 64 clocks.
    logic [1:0] div = '0;
    logic [3:0] sign = '0;
    always @(posedge clk) begin
        div <= div + 2'd1;
        if (div == 2'd3) sign <= sign + 4'd1;
    end
    assign bus.bit_tick = (div == 2'd3);
    assign bus.sign_cnt = sign;

    logic [7:0] b [4] = '{8'h10, 8'hBB, 8'h12, 8'h13};
    logic [7:0] rx_byte = '0;
    logic [7:0] exp_byte = '0;
    logic       corrupt = 1'b0;
    logic [2:0] ok_mask = 3'b111;
    logic       prev_tx_en = 1'b0;
    int tx_frames = 0, done_cnt = 0, good_ticks = 0;
    int n_tests = 0, n_fail = 0;

    // Receiver model: loops back the transmitted byte; CRC result chosen per attempt.
    assign bus.rx_data   = rx_byte ^ {7'd0, corrupt};
    assign bus.rx_crc_ok = ok_mask[(tx_frames < 1) ? 0 : (tx_frames > 3) ? 2 : tx_frames - 1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.tx_en && !prev_tx_en) check("tx_align", 32'(bus.sign_cnt), 0);
        if (bus.tx_en) begin
            rx_byte = bus.tx_data;
            if (bus.bit_tick && bus.tx_data == exp_byte) good_ticks++;
            if (bus.bit_tick && bus.sign_cnt == 4'd15) begin
                tx_frames++;
                check("tx_stable", good_ticks, 16);
                good_ticks = 0;
            end
        end else begin
            good_ticks = 0;
        end
        prev_tx_en = bus.tx_en;
    end

    task automatic wait_done(input string tag, input int eid, input logic eok, input int eframes);
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_id"}, 32'(bus.done_id), eid);
        check({tag, "_ok"}, 32'(bus.done_ok), 32'(eok));
        check({tag, "_frames"}, tx_frames, eframes);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        tx_frames = 0;
    endtask

    initial begin
        int n;
        int saved;
        bus.req = '0;
        bus.req_data = {b[3], b[2], b[1], b[0]};
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_tx_en", 32'(bus.tx_en), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_done_id", 32'(bus.done_id), 0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_byte = b[1];
        bus.req = 4'b0010;
        wait_done("t1", 1, 1'b1, 1);
        bus.req = '0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_byte = b[(k + 1) % 4];
            wait_done("t2", (k + 1) % 4, 1'b1, 1);
        end
        bus.req = '0;

        exp_byte = b[2];
        ok_mask = 3'b000;
        bus.req = 4'b0100;
        wait_done("t3", 2, 1'b0, 3);
        bus.req = '0;

        exp_byte = b[3];
        ok_mask = 3'b010;
        bus.req = 4'b1000;
        wait_done("t4", 3, 1'b1, 2);
        bus.req = '0;

        exp_byte = b[0];
        ok_mask = 3'b111;
        corrupt = 1'b1;
        bus.req = 4'b0001;
        wait_done("t4b", 0, 1'b0, 3);
        corrupt = 1'b0;
        bus.req = '0;

        bus.req = 4'b0001;
        n = 0;
        while (!(bus.tx_en && bus.sign_cnt == 4'd7) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("t5_send_timeout", 0, 1);
        saved = done_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_grant", 32'(bus.grant), 0);
        check("t5_tx_en", 32'(bus.tx_en), 0);
        check("t5_busy", 32'(bus.busy), 0);
        bus.req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_no_done", done_cnt, saved);
        tx_frames = 0;
        bus.req = 4'b0001;
        wait_done("t5_new", 0, 1'b1, 1);
        bus.req = '0;

        exp_byte = b[2];
        n = 0;
        while (!(bus.bit_tick && bus.sign_cnt == 4'd15) && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.req = 4'b0100;
        n = 0;
        while (!bus.tx_en && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 2) check("t6_grant", 32'(bus.grant), 32'h4);
        end
        check("t6_latency", n, 65);
        wait_done("t6", 2, 1'b1, 1);
        bus.req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
